uart_cmd_sequencer: RTL and testbench
=====================================

# uart_cmd_sequencer

Parses framed register-write commands from the byte stream delivered by `uart_receive` (`DATA`/`RXD_READY`), then presents each validated command to the camera register-write path (the MT9V034 I2C master) over a valid/ready handshake. It sits between the UART receiver and the sensor configuration master. It handles framing, inter-byte timeout, integrity checking and single-entry buffering, so the host can stream configuration at line rate.

## Interface
- `TIMEOUT_CYCLES`, default 2700: maximum idle cycles between bytes inside a packet; 100 µs at 27 MHz.
- `SYNC_BYTE`, default 8'hA5: packet start marker.
- `CLK`, input, 1: system clock, 27 MHz.
- `RST`, input, 1: asynchronous, active-high reset.
- `RX_DATA`, input, 8: received byte; valid only while `RX_READY` is high.
- `RX_READY`, input, 1: single-cycle strobe, one per received byte.
- `CMD_ADDR`, output, 8: sensor register address.
- `CMD_DATA`, output, 16: register value, MSB first on the wire.
- `CMD_VALID`, output, 1: a command is held; stays high until accepted.
- `CMD_READY`, input, 1: the consumer accepts on `CMD_VALID && CMD_READY`.
- `ERR_CHECKSUM`, output, 1: one-cycle pulse when a packet is rejected on checksum.
- `ERR_TIMEOUT`, output, 1: one-cycle pulse when a packet is aborted by the gap timer.
- `ERR_OVERRUN`, output, 1: one-cycle pulse when a completed packet is dropped because the holding register is full.
- `BUSY`, output, 1: high when the parser state is not `S_HUNT`.

## Operation
- Packet format: `SYNC`, `ADDR`, `DHI`, `DLO`, then `CSUM` if the checksum feature is compiled in.
- Parser states: `S_HUNT` → `S_ADDR` → `S_DHI` → `S_DLO` → `S_CSUM` → `S_HUNT`.
  - `S_HUNT`: bytes other than `SYNC_BYTE` are discarded silently.
  - Each other state advances on `RX_READY` and latches the byte into its field.
- Checksum: `CSUM` must equal `ADDR ^ DHI ^ DLO`.
  - On mismatch: pulse `ERR_CHECKSUM` and return to `S_HUNT`; the holding register is untouched.
- Packet completion means the last byte was received and passed its check. On completion:
  - If the holding register is empty, or is being accepted in the same cycle, load `ADDR`/`DATA` and assert `CMD_VALID`.
  - Otherwise, drop the packet and pulse `ERR_OVERRUN`.
  - In both cases the parser returns to `S_HUNT`.
- Gap timer:
  - Cleared on every `RX_READY` and held at 0 in `S_HUNT`.
  - Counts up in every other state.
  - When it reaches `TIMEOUT_CYCLES-1` with no `RX_READY` that cycle: go to `S_HUNT` and pulse `ERR_TIMEOUT`.
- Simultaneous events:
  - `RX_READY` in the expiry cycle: the byte is processed and the timer clears, so no timeout occurs.
  - Completion and accept in the same cycle: the holding register reloads and `CMD_VALID` stays high; no overrun.
- A `SYNC_BYTE` value received mid-packet is treated as data, not as a resync.

## Timing
- All outputs are registered.
- Reset values: `CMD_ADDR`=0, `CMD_DATA`=0, `CMD_VALID`=0, all `ERR_*`=0, `BUSY`=0. State resets to `S_HUNT` and the timer to 0.
- Latency: `CMD_VALID` rises on the clock edge after the cycle in which the final byte's `RX_READY` is high. Error pulses follow the same one-cycle latency.
- `CMD_VALID` deasserts on the edge after acceptance, unless a reload occurs in that same cycle.
- `CMD_ADDR` and `CMD_DATA` are stable while `CMD_VALID && !CMD_READY`.
- Reset mid-packet or with a command held: all state is lost asynchronously and no error pulse is emitted.
- Throughput: one command per packet. The consumer may hold `CMD_READY` low indefinitely; further packets then overrun.

## Configuration
- `UART_CMD_CHECKSUM_EN` defined: 5-byte packets, the `S_CSUM` state exists, and `ERR_CHECKSUM` is live.
- `UART_CMD_CHECKSUM_EN` undefined:
  - 4-byte packets; completion occurs on `DLO`.
  - `S_CSUM` is not built.
  - `ERR_CHECKSUM` is tied to 0.

## Structure
- Package `uart_cmd_pkg` holds:
  - the `SYNC_BYTE` default;
  - the state enum (`S_HUNT`, `S_ADDR`, `S_DHI`, `S_DLO`, `S_CSUM`);
  - the packet-length constant, 4 or 5 depending on the macro.
- Sub-module `uart_cmd_gap_timer`:
  - inputs: `clear`, `enable`;
  - output: `expire`;
  - parameterised by `TIMEOUT_CYCLES`, with counter width `$clog2(TIMEOUT_CYCLES)`.
- Parser FSM, holding register and error pulses live in the top module.

## Test plan
- Valid packet, checksum on: bytes A5 20 01 23 02 with `CMD_READY`=1 → a 1-cycle `CMD_VALID` with `CMD_ADDR`=20, `CMD_DATA`=0123, and no errors.
- Bad checksum: bytes A5 20 01 23 FF → `ERR_CHECKSUM` pulses once, `CMD_VALID` stays 0, `BUSY` returns to 0.
- Timeout: A5 20, then silence for `TIMEOUT_CYCLES` cycles → `ERR_TIMEOUT` pulses once. A following valid packet is accepted normally.
- Back-pressure: `CMD_READY`=0, two valid packets → the first is held stable, the second pulses `ERR_OVERRUN`. Raising `CMD_READY` then delivers the first packet only.
- Leading junk and expiry collision: 00 FF A5 0D 00 07 0A, with one byte arriving exactly on the expiry cycle → `CMD_ADDR`=0D, `CMD_DATA`=0007, and no `ERR_TIMEOUT`.
- Asynchronous reset asserted after `DHI` → all outputs read 0 immediately. A subsequent complete packet parses correctly.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
// Packet length depends on UART_CMD_CHECKSUM_EN (5 bytes with checksum, 4 without).
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

`ifdef UART_CMD_CHECKSUM_EN
    localparam int PKT_LEN = 5;
`else
    localparam int PKT_LEN = 4;
`endif

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_DHI,
        S_DLO,
        S_CSUM
    } state_t;

    function automatic logic [7:0] packet_csum(input logic [7:0] addr,
                                               input logic [7:0] dhi,
                                               input logic [7:0] dlo);
        return addr ^ dhi ^ dlo;
    endfunction

endpackage

// File: rtl/uart_cmd_gap_timer.sv
// Inter-byte gap timer: counts idle cycles inside a packet and flags expiry
// once TIMEOUT_CYCLES-1 is reached; saturates there until cleared.
module uart_cmd_gap_timer #(
    parameter int TIMEOUT_CYCLES = 2700
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses SYNC/ADDR/DHI/DLO[/CSUM] packets from the UART byte stream and holds
// one command for the register-write master. Checksum gated by UART_CMD_CHECKSUM_EN.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 2700,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_READY,
    output logic [7:0]  CMD_ADDR,
    output logic [15:0] CMD_DATA,
    output logic        CMD_VALID,
    input  logic        CMD_READY,
    output logic        ERR_CHECKSUM,
    output logic        ERR_TIMEOUT,
    output logic        ERR_OVERRUN,
    output logic        BUSY
);

    state_t      state;
    state_t      state_next;
    logic [7:0]  addr_q;
    logic [7:0]  dhi_q;
    logic [15:0] data_new;
    logic        complete;
    logic        timeout;
    logic        gap_expire;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]  dlo_q;
    logic        csum_bad;
    logic        err_checksum_q;
`endif

    uart_cmd_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk   (CLK),
        .rst   (RST),
        .clear (RX_READY || (state == S_HUNT)),
        .enable(state != S_HUNT),
        .expire(gap_expire)
    );

    // A byte arriving on the expiry cycle wins over the timeout.
    always_comb begin
        state_next = state;
        complete   = 1'b0;
        timeout    = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        csum_bad   = 1'b0;
        data_new   = {dhi_q, dlo_q};
`else
        data_new   = {dhi_q, RX_DATA};
`endif
        if ((state != S_HUNT) && !RX_READY && gap_expire) begin
            timeout    = 1'b1;
            state_next = S_HUNT;
        end else if (RX_READY) begin
            case (state)
                S_HUNT: if (RX_DATA == SYNC_BYTE) state_next = S_ADDR;
                S_ADDR: state_next = S_DHI;
                S_DHI:  state_next = S_DLO;
`ifdef UART_CMD_CHECKSUM_EN
                S_DLO:  state_next = S_CSUM;
                S_CSUM: begin
                    state_next = S_HUNT;
                    if (RX_DATA == packet_csum(addr_q, dhi_q, dlo_q)) begin
                        complete = 1'b1;
                    end else begin
                        csum_bad = 1'b1;
                    end
                end
`else
                S_DLO: begin
                    state_next = S_HUNT;
                    complete   = 1'b1;
                end
`endif
                default: state_next = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_HUNT;
            BUSY        <= 1'b0;
            addr_q      <= '0;
            dhi_q       <= '0;
            CMD_ADDR    <= '0;
            CMD_DATA    <= '0;
            CMD_VALID   <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
            ERR_OVERRUN <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            dlo_q          <= '0;
            err_checksum_q <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            BUSY        <= (state_next != S_HUNT);
            ERR_TIMEOUT <= timeout;
            ERR_OVERRUN <= complete && CMD_VALID && !CMD_READY;
`ifdef UART_CMD_CHECKSUM_EN
            err_checksum_q <= csum_bad;
`endif
            if (RX_READY) begin
                case (state)
                    S_ADDR: addr_q <= RX_DATA;
                    S_DHI:  dhi_q  <= RX_DATA;
`ifdef UART_CMD_CHECKSUM_EN
                    S_DLO:  dlo_q  <= RX_DATA;
`endif
                    default: ;
                endcase
            end
            // Reload is allowed when the held command leaves in this same cycle.
            if (complete && (!CMD_VALID || CMD_READY)) begin
                CMD_ADDR  <= addr_q;
                CMD_DATA  <= data_new;
                CMD_VALID <= 1'b1;
            end else if (CMD_VALID && CMD_READY) begin
                CMD_VALID <= 1'b0;
            end
        end
    end

`ifdef UART_CMD_CHECKSUM_EN
    assign ERR_CHECKSUM = err_checksum_q;
`else
    assign ERR_CHECKSUM = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: directed scenarios plus random
// packet traffic, compared every cycle against a byte-queue reference model.
module tb_uart_cmd_sequencer;
    import uart_cmd_pkg::*;

    localparam int         TO   = 20;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_DATA;
    logic        RX_READY;
    logic [7:0]  CMD_ADDR;
    logic [15:0] CMD_DATA;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        ERR_CHECKSUM;
    logic        ERR_TIMEOUT;
    logic        ERR_OVERRUN;
    logic        BUSY;

    int checks   = 0;
    int failures = 0;

    bit          mInPkt;
    logic [7:0]  mPkt[$];
    int          mGap;
    bit          mValid;
    logic [7:0]  mAddr;
    logic [15:0] mData;
    bit          mErrCs;
    bit          mErrTo;
    bit          mErrOv;
    bit          randomReady;
    bit          fixedReady;

    always #5 CLK = ~CLK;

    uart_cmd_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .SYNC_BYTE     (SYNC)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_DATA     (RX_DATA),
        .RX_READY    (RX_READY),
        .CMD_ADDR    (CMD_ADDR),
        .CMD_DATA    (CMD_DATA),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .ERR_CHECKSUM(ERR_CHECKSUM),
        .ERR_TIMEOUT (ERR_TIMEOUT),
        .ERR_OVERRUN (ERR_OVERRUN),
        .BUSY        (BUSY)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("cmd_valid", 32'(CMD_VALID), 32'(mValid));
        checkOutput("cmd_addr", 32'(CMD_ADDR), 32'(mAddr));
        checkOutput("cmd_data", 32'(CMD_DATA), 32'(mData));
        checkOutput("err_checksum", 32'(ERR_CHECKSUM), 32'(mErrCs));
        checkOutput("err_timeout", 32'(ERR_TIMEOUT), 32'(mErrTo));
        checkOutput("err_overrun", 32'(ERR_OVERRUN), 32'(mErrOv));
        checkOutput("busy", 32'(BUSY), 32'(mInPkt));
    endtask

    task automatic modelReset();
        mInPkt = 0;
        mPkt.delete();
        mGap   = 0;
        mValid = 0;
        mAddr  = '0;
        mData  = '0;
        mErrCs = 0;
        mErrTo = 0;
        mErrOv = 0;
    endtask

    // Packet-level reference: collect bytes after SYNC, judge the packet once complete.
    task automatic modelStep(input bit rdy, input logic [7:0] d, input bit cr);
        bit accept;
        bit newValid;
        accept   = mValid && cr;
        newValid = mValid && !accept;
        mErrCs   = 0;
        mErrTo   = 0;
        mErrOv   = 0;
        if (!mInPkt) begin
            if (rdy && d == SYNC) begin
                mInPkt = 1;
                mPkt.delete();
                mGap = 0;
            end
        end else if (rdy) begin
            mPkt.push_back(d);
            mGap = 0;
            if (mPkt.size() == PKT_LEN - 1) begin
                mInPkt = 0;
                if (PKT_LEN == 5 && mPkt[3] != (mPkt[0] ^ mPkt[1] ^ mPkt[2])) begin
                    mErrCs = 1;
                end else if (mValid && !accept) begin
                    mErrOv = 1;
                end else begin
                    mAddr    = mPkt[0];
                    mData    = {mPkt[1], mPkt[2]};
                    newValid = 1;
                end
            end
        end else begin
            mGap++;
            if (mGap == TO) begin
                mErrTo = 1;
                mInPkt = 0;
            end
        end
        mValid = newValid;
    endtask

    task automatic applyStimulus(input bit rdy, input logic [7:0] d);
        bit cr;
        cr = randomReady ? ($urandom_range(0, 3) != 0) : fixedReady;
        @(negedge CLK);
        RX_READY  = rdy;
        RX_DATA   = d;
        CMD_READY = cr;
        modelStep(rdy, d, cr);
        @(posedge CLK);
        #1;
        checkAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic sendPacket(input logic [7:0] a, input logic [15:0] v, input bit badCsum, input int maxGap);
        logic [7:0] bytes[$];
        logic [7:0] cs;
        cs = a ^ v[15:8] ^ v[7:0];
        bytes = '{SYNC, a, v[15:8], v[7:0]};
        if (PKT_LEN == 5) bytes.push_back(badCsum ? ~cs : cs);
        foreach (bytes[i]) begin
            if (i > 0 && maxGap > 0) idleCycles($urandom_range(0, maxGap));
            applyStimulus(1'b1, bytes[i]);
        end
    endtask

    initial begin
        RST         = 1'b1;
        RX_READY    = 1'b0;
        RX_DATA     = 8'h00;
        CMD_READY   = 1'b0;
        randomReady = 0;
        fixedReady  = 1;
        modelReset();
        #1;
        checkAll();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Basic packet accepted immediately
        sendPacket(8'h20, 16'h0123, 0, 0);
        idleCycles(3);

        // Corrupted checksum (only meaningful with the checksum byte present)
        sendPacket(8'h20, 16'h0123, 1, 0);
        idleCycles(3);

        // Truncated packet times out, then a normal packet follows
        applyStimulus(1'b1, SYNC);
        applyStimulus(1'b1, 8'h20);
        idleCycles(TO + 3);
        sendPacket(8'h44, 16'hBEEF, 0, 0);
        idleCycles(2);

        // Back-pressure: first held, second overruns, then release
        fixedReady = 0;
        sendPacket(8'h31, 16'h1111, 0, 0);
        idleCycles(2);
        sendPacket(8'h32, 16'h2222, 0, 0);
        idleCycles(3);
        fixedReady = 1;
        idleCycles(3);

        // Leading junk and a byte landing exactly on the expiry cycle
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        applyStimulus(1'b1, SYNC);
        applyStimulus(1'b1, 8'h0D);
        applyStimulus(1'b1, 8'h00);
        idleCycles(TO - 1);
        applyStimulus(1'b1, 8'h07);
        if (PKT_LEN == 5) applyStimulus(1'b1, 8'h0A);
        idleCycles(3);

        // Asynchronous reset mid-packet with a command held
        fixedReady = 0;
        sendPacket(8'h55, 16'hA5A5, 0, 0);
        applyStimulus(1'b1, SYNC);
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b1, 8'h22);
        @(negedge CLK);
        RX_READY = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_cmd_valid", 32'(CMD_VALID), 32'h0);
        checkOutput("rst_cmd_addr", 32'(CMD_ADDR), 32'h0);
        checkOutput("rst_cmd_data", 32'(CMD_DATA), 32'h0);
        checkOutput("rst_busy", 32'(BUSY), 32'h0);
        checkOutput("rst_errors", {29'h0, ERR_CHECKSUM, ERR_TIMEOUT, ERR_OVERRUN}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        fixedReady = 1;
        sendPacket(8'h66, 16'h7788, 0, 0);
        idleCycles(2);

        // Random traffic with random back-pressure
        randomReady = 1;
        for (int n = 0; n < 400; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                sendPacket(8'($urandom), 16'($urandom), 0, ($urandom_range(0, 7) == 0) ? TO : 2);
            end else if (kind == 6) begin
                sendPacket(8'($urandom), 16'($urandom), 1, 1);
            end else if (kind == 7) begin
                applyStimulus(1'b1, 8'($urandom));
            end else if (kind == 8) begin
                applyStimulus(1'b1, SYNC);
                applyStimulus(1'b1, 8'($urandom));
                idleCycles($urandom_range(TO - 2, TO + 2));
            end else begin
                idleCycles($urandom_range(0, 4));
            end
        end
        randomReady = 0;
        fixedReady  = 1;
        idleCycles(TO + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
